// File: rtl/dmem_responder.sv
// Data-memory responder at the memory end of the MEM-stage load/store port.
// One request at a time: accept, wait LATENCY cycles, present a one-cycle
// response. Stores commit at acceptance; loads capture at acceptance.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no request outstanding; a request with i_req=1 is accepted
//   WAIT  | request accepted, counting down the programmed wait cycles
//   RESP  | o_valid strobe; busy drops so the pipeline advances
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic        i_write,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_writeData,
   input  logic [1:0]  i_memSize,
   output logic        o_busy,
   output logic        o_valid,
   output logic [31:0] o_readData,
   output logic        o_error
);

   localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WAIT_INIT  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        valid_q, valid_d;
   logic        error_q, error_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] hold_data_q, hold_data_d;
   logic        hold_err_q, hold_err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]      offset;
   logic [IDX_W-1:0] word_idx;
   logic             req_err;
   logic             accept;
   logic [3:0]       lane_we;
   logic [31:0]      lane_wdata;
   logic [31:0]      rd_word;
   logic [31:0]      load_val;

   // Address decode, error checks, lane enables and load extraction.
   always_comb begin
      offset   = i_addr - BASE_ADDR;
      word_idx = offset[IDX_W+1:2];
      req_err  = (i_memSize == 2'b11)
               | ((i_memSize == SZ_HALF) & i_addr[0])
               | ((i_memSize == SZ_WORD) & (i_addr[1:0] != 2'b00))
               | (offset >= SPAN_BYTES);
      accept   = (state_q == ST_IDLE) & i_req;
      rd_word  = mem[word_idx];

      lane_we    = 4'b0000;
      lane_wdata = i_writeData;
      load_val   = 32'd0;
      case (i_memSize)
         SZ_BYTE: begin
            lane_we    = 4'b0001 << i_addr[1:0];
            lane_wdata = {4{i_writeData[7:0]}};
            load_val   = {24'd0, rd_word[8*i_addr[1:0] +: 8]};
         end
         SZ_HALF: begin
            lane_we    = i_addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{i_writeData[15:0]}};
            load_val   = i_addr[1] ? {16'd0, rd_word[31:16]} : {16'd0, rd_word[15:0]};
         end
         SZ_WORD: begin
            lane_we    = 4'b1111;
            lane_wdata = i_writeData;
            load_val   = rd_word;
         end
         default: begin
            lane_we    = 4'b0000;
            lane_wdata = i_writeData;
            load_val   = 32'd0;
         end
      endcase
   end

   // Next-state, wait counter and registered response outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hold_data_d = hold_data_q;
      hold_err_d  = hold_err_q;
      valid_d     = 1'b0;
      error_d     = 1'b0;
      rdata_d     = 32'd0;
      case (state_q)
         ST_IDLE: begin
            if (i_req) begin
               hold_err_d  = req_err;
               hold_data_d = (req_err | i_write) ? 32'd0 : load_val;
               if (LATENCY == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_RESP) begin
         valid_d = 1'b1;
         error_d = hold_err_d;
         rdata_d = hold_data_d;
      end
   end

   // Control and response registers; reset aborts any outstanding response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
         rdata_q     <= 32'd0;
         hold_data_q <= 32'd0;
         hold_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
         rdata_q     <= rdata_d;
         hold_data_q <= hold_data_d;
         hold_err_q  <= hold_err_d;
      end
   end

   // Store commit at the acceptance edge; array contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && accept && i_write && !req_err) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
         end
      end
   end

   assign o_busy     = ((state_q == ST_IDLE) & i_req) | (state_q == ST_WAIT);
   assign o_valid    = valid_q;
   assign o_error    = error_q;
   assign o_readData = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 2, 0, 5)
// share the data/address inputs, each with its own request line.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_v;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  sz;
   logic [2:0]  busy_v;
   logic [2:0]  valid_v;
   logic [2:0]  err_v;
   logic [31:0] rd0, rd1, rd2;

   int n_cmp  = 0;
   int n_fail = 0;
   logic mon_en = 1'b0;
   int tag = 0;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      logic [15:0] id;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0000_0000), .LATENCY(2)) u_lat2 (
      .clk(clk), .reset(reset), .i_req(req_v[0]), .i_write(wr), .i_addr(addr),
      .i_writeData(wdata), .i_memSize(sz), .o_busy(busy_v[0]), .o_valid(valid_v[0]),
      .o_readData(rd0), .o_error(err_v[0]));

   dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_1000), .LATENCY(0)) u_lat0 (
      .clk(clk), .reset(reset), .i_req(req_v[1]), .i_write(wr), .i_addr(addr),
      .i_writeData(wdata), .i_memSize(sz), .o_busy(busy_v[1]), .o_valid(valid_v[1]),
      .o_readData(rd1), .o_error(err_v[1]));

   dmem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0000_0000), .LATENCY(5)) u_lat5 (
      .clk(clk), .reset(reset), .i_req(req_v[2]), .i_write(wr), .i_addr(addr),
      .i_writeData(wdata), .i_memSize(sz), .o_busy(busy_v[2]), .o_valid(valid_v[2]),
      .o_readData(rd2), .o_error(err_v[2]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_of(input int n);
      case (n)
         0:       return rd0;
         1:       return rd1;
         default: return rd2;
      endcase
   endfunction

   function automatic int qsize(input int n);
      case (n)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic push_exp(input int n, input logic [31:0] d, input logic e);
      exp_t x;
      x.data = d;
      x.err  = e;
      x.id   = 16'(tag);
      tag++;
      case (n)
         0:       q0.push_back(x);
         1:       q1.push_back(x);
         default: q2.push_back(x);
      endcase
   endtask

   function automatic exp_t pop_exp(input int n);
      case (n)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   // Monitor: every response is matched against the scoreboard; between
   // responses the data and error outputs must be quiet.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int n = 0; n < 3; n++) begin
            if (valid_v[n]) begin
               if (qsize(n) == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_valid inst%0d: got valid=1 required no response", n);
               end else begin
                  exp_t e;
                  e = pop_exp(n);
                  chk($sformatf("rdata inst%0d id%0d", n, e.id), rd_of(n), e.data);
                  chk($sformatf("error inst%0d id%0d", n, e.id), {31'd0, err_v[n]}, {31'd0, e.err});
               end
            end else begin
               chk($sformatf("quiet inst%0d", n), {err_v[n], rd_of(n)[30:0]} | {31'd0, rd_of(n)[31]},
                   32'd0);
            end
         end
      end
   end

   // Issue one request from IDLE (called at posedge+1), hold it while busy,
   // and check the busy length and that the response lands right after.
   task automatic do_req(input int n, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic [31:0] exp_d, input logic exp_e,
                         input int exp_busy, input string nm);
      int cyc;
      push_exp(n, exp_d, exp_e);
      wr = w; addr = a; wdata = d; sz = s;
      req_v[n] = 1'b1;
      #1;
      cyc = 0;
      while (busy_v[n] && cyc < 40) begin
         cyc++;
         @(posedge clk);
         #1;
      end
      chk({nm, " busy_cycles"}, 32'(cyc), 32'(exp_busy));
      chk({nm, " valid_after_busy"}, {31'd0, valid_v[n]}, 32'd1);
      req_v[n] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      time t_a, t_b;
      reset = 1'b1; req_v = 3'b000; wr = 1'b0; addr = 32'd0; wdata = 32'd0; sz = 2'b10;

      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         chk("reset_busy",  {31'd0, busy_v[0]},  32'd0);
         chk("reset_valid", {31'd0, valid_v[0]}, 32'd0);
         chk("reset_rdata", rd0,                 32'd0);
         chk("reset_error", {31'd0, err_v[0]},   32'd0);
      end
      reset = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // LATENCY=2 instance
      do_req(0, 1'b1, 32'h100,  32'hDEAD_BEEF, 2'b10, 32'h0,         1'b0, 3, "st_w_100");
      do_req(0, 1'b0, 32'h100,  32'h0,         2'b10, 32'hDEAD_BEEF, 1'b0, 3, "ld_w_100");
      do_req(0, 1'b1, 32'h102,  32'hFFFF_FF5A, 2'b00, 32'h0,         1'b0, 3, "st_b_102");
      do_req(0, 1'b0, 32'h102,  32'h0,         2'b01, 32'h0000_DE5A, 1'b0, 3, "ld_h_102");
      do_req(0, 1'b0, 32'h101,  32'h0,         2'b00, 32'h0000_00BE, 1'b0, 3, "ld_b_101");
      do_req(0, 1'b0, 32'h103,  32'h0,         2'b01, 32'h0,         1'b1, 3, "ld_h_103_misal");
      do_req(0, 1'b1, 32'h3FFC, 32'hCAFE_F00D, 2'b10, 32'h0,         1'b0, 3, "st_w_last");
      do_req(0, 1'b1, 32'h0,    32'h1122_3344, 2'b10, 32'h0,         1'b0, 3, "st_w_first");
      do_req(0, 1'b1, 32'h4000, 32'hBADB_AD00, 2'b10, 32'h0,         1'b1, 3, "st_w_oob");
      do_req(0, 1'b0, 32'h3FFC, 32'h0,         2'b10, 32'hCAFE_F00D, 1'b0, 3, "ld_w_last");
      do_req(0, 1'b0, 32'h0,    32'h0,         2'b10, 32'h1122_3344, 1'b0, 3, "ld_w_first");
      do_req(0, 1'b0, 32'h100,  32'h0,         2'b11, 32'h0,         1'b1, 3, "ld_sz11");
      do_req(0, 1'b1, 32'h102,  32'h5555_5555, 2'b10, 32'h0,         1'b1, 3, "st_w_misal");
      do_req(0, 1'b0, 32'h100,  32'h0,         2'b10, 32'hDE5A_BEEF, 1'b0, 3, "ld_w_100_again");
      do_req(0, 1'b1, 32'h104,  32'h0102_0304, 2'b10, 32'h0,         1'b0, 3, "st_w_104");
      do_req(0, 1'b1, 32'h106,  32'hAAAA_1234, 2'b01, 32'h0,         1'b0, 3, "st_h_106");
      do_req(0, 1'b0, 32'h104,  32'h0,         2'b10, 32'h1234_0304, 1'b0, 3, "ld_w_104");
      do_req(0, 1'b0, 32'h107,  32'h0,         2'b00, 32'h0000_0012, 1'b0, 3, "ld_b_107");
      do_req(0, 1'b0, 32'h104,  32'h0,         2'b01, 32'h0000_0304, 1'b0, 3, "ld_h_104");

      // LATENCY=0 instance, base 0x1000, 64 words
      do_req(1, 1'b1, 32'h1000, 32'hA5A5_0F0F, 2'b10, 32'h0,         1'b0, 1, "l0_st_w_1000");
      do_req(1, 1'b1, 32'h1004, 32'h1357_9BDF, 2'b10, 32'h0,         1'b0, 1, "l0_st_w_1004");
      do_req(1, 1'b0, 32'h0FFC, 32'h0,         2'b10, 32'h0,         1'b1, 1, "l0_below_base");
      do_req(1, 1'b0, 32'h1100, 32'h0,         2'b10, 32'h0,         1'b1, 1, "l0_above_top");
      do_req(1, 1'b0, 32'h1003, 32'h0,         2'b00, 32'h0000_00A5, 1'b0, 1, "l0_ld_b_1003");

      // Back-to-back loads with i_req held high throughout
      push_exp(1, 32'hA5A5_0F0F, 1'b0);
      push_exp(1, 32'h0000_0057, 1'b0);
      wr = 1'b0; addr = 32'h1000; sz = 2'b10; req_v[1] = 1'b1;
      #1;
      chk("b2b_busy_first", {31'd0, busy_v[1]}, 32'd1);
      @(posedge clk);
      #1;
      t_a = $time;
      chk("b2b_resp1_busy",  {31'd0, busy_v[1]},  32'd0);
      chk("b2b_resp1_valid", {31'd0, valid_v[1]}, 32'd1);
      addr = 32'h1006; sz = 2'b00;
      @(posedge clk);
      #1;
      chk("b2b_idle_busy",  {31'd0, busy_v[1]},  32'd1);
      chk("b2b_idle_valid", {31'd0, valid_v[1]}, 32'd0);
      @(posedge clk);
      #1;
      t_b = $time;
      chk("b2b_resp2_valid", {31'd0, valid_v[1]}, 32'd1);
      chk("b2b_spacing", 32'(t_b - t_a), 32'd20);
      req_v[1] = 1'b0;
      @(posedge clk);
      #1;

      // LATENCY=5 instance: reset in WAIT aborts the response, store persists
      wr = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; sz = 2'b10; req_v[2] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("l5_busy_in_wait", {31'd0, busy_v[2]}, 32'd1);
      reset = 1'b1; req_v[2] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("l5_busy_after_reset", {31'd0, busy_v[2]}, 32'd0);
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         chk("l5_no_valid", {31'd0, valid_v[2]}, 32'd0);
      end
      do_req(2, 1'b0, 32'h20, 32'h0, 2'b10, 32'h1234_5678, 1'b0, 6, "l5_ld_w_20");

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
